// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared types and constants for the UART pixel loader
//
// Purpose: FSM state encoding, BRAM address/pixel widths and the default
//          frame size and inter-byte timeout used by uart_pixel_loader.
// Ports:   none (package)
package uart_loader_pkg;

  typedef enum logic [1:0] {
    WAIT_R = 2'd0,
    WAIT_G = 2'd1,
    WAIT_B = 2'd2
  } loader_state_t;

  localparam int ADDR_W = 18;
  localparam int PIX_W  = 24;

  localparam int DEF_IMG_PIXELS     = 76800;
  localparam int DEF_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/uart_pixel_loader_byte_gap_timer.sv
// rtl/uart_pixel_loader_byte_gap_timer.sv - inter-byte gap counter for the pixel loader
//
// Purpose: counts clk cycles while run=1 and flags expired when the count
//          reaches LIMIT. The count restarts on clear, when run drops, and
//          in the cycle after it expires.
// Ports:
//   clk     in  clock
//   reset   in  synchronous active-high reset
//   run     in  count enable (loader is mid-pixel)
//   clear   in  restart the count (a byte was accepted)
//   expired out LIMIT cycles have elapsed since the last restart
module byte_gap_timer #(
  parameter int LIMIT = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  assign expired = run && (count == CNT_W'(LIMIT));

  always_ff @(posedge clk) begin
    if (reset || clear || !run || expired) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_pixel_loader.sv
// rtl/uart_pixel_loader.sv - assembles UART bytes into RGB pixels and writes them to BRAM
//
// Purpose: collects bytes in fixed R, G, B order and issues one BRAM write per
//          pixel, walking addresses 0..IMG_PIXELS-1 and wrapping so frames
//          reload continuously. Optional macro UART_LOADER_TIMEOUT_EN adds an
//          inter-byte gap timer that discards a stale partial pixel.
// Ports:
//   clk          in  100 MHz clock
//   reset        in  synchronous active-high reset
//   rx_data[7:0] in  received byte, valid with rx_ready
//   rx_ready     in  one-cycle strobe per received byte
//   wea          out BRAM write enable (one cycle per pixel)
//   addra[17:0]  out BRAM write address
//   dina[23:0]   out pixel {R,G,B}
//   frame_done   out pulse alongside the write of the last pixel in a frame
//   timeout_err  out sticky: a partial pixel was discarded on timeout
//   state[1:0]   out current FSM state (debug)
module uart_pixel_loader
  import uart_loader_pkg::*;
#(
  parameter int IMG_PIXELS     = DEF_IMG_PIXELS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [PIX_W-1:0]  dina,
  output logic              frame_done,
  output logic              timeout_err,
  output logic [1:0]        state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_PIXELS - 1);

  loader_state_t cur_state;
  logic [7:0]    r_byte;
  logic [7:0]    g_byte;
  logic          gap_expired;

  assign state = cur_state;

`ifdef UART_LOADER_TIMEOUT_EN
  byte_gap_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .run     ((cur_state == WAIT_G) || (cur_state == WAIT_B)),
    .clear   (rx_ready),
    .expired (gap_expired)
  );
`else
  assign gap_expired = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state  <= WAIT_R;
      addra      <= '0;
      wea        <= 1'b0;
      dina       <= '0;
      frame_done <= 1'b0;
      r_byte     <= '0;
      g_byte     <= '0;
`ifdef UART_LOADER_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      wea        <= 1'b0;
      frame_done <= 1'b0;

      // addra holds the address of the pending write; it advances only once
      // that write has been presented, so it is stable while wea=1.
      if (wea) begin
        addra <= (addra == LAST_ADDR) ? '0 : addra + 1'b1;
      end

      if (gap_expired) begin
        // Stale partial pixel is dropped; a byte landing in this very cycle
        // starts the next pixel as R.
`ifdef UART_LOADER_TIMEOUT_EN
        timeout_err <= 1'b1;
`endif
        if (rx_ready) begin
          r_byte    <= rx_data;
          cur_state <= WAIT_G;
        end else begin
          cur_state <= WAIT_R;
        end
      end else begin
        case (cur_state)
          WAIT_R: begin
            if (rx_ready) begin
              r_byte    <= rx_data;
              cur_state <= WAIT_G;
            end
          end
          WAIT_G: begin
            if (rx_ready) begin
              g_byte    <= rx_data;
              cur_state <= WAIT_B;
            end
          end
          WAIT_B: begin
            if (rx_ready) begin
              wea        <= 1'b1;
              dina       <= {r_byte, g_byte, rx_data};
              frame_done <= (addra == LAST_ADDR);
              cur_state  <= WAIT_R;
            end
          end
          default: cur_state <= WAIT_R;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_pixel_loader.sv
// tb/tb_uart_pixel_loader.sv - scoreboard bench for uart_pixel_loader
module tb_uart_pixel_loader;

  localparam int IMG     = 4;
  localparam int TIMEOUT = 50;

  typedef struct packed {
    logic [17:0] addr;
    logic [23:0] data;
    logic        fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic        wea;
  logic [17:0] addra;
  logic [23:0] dina;
  logic        frame_done;
  logic        timeout_err;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];
  exp_t mon_e;

  logic [7:0]  m_r, m_g;
  int          m_idx;
  logic [17:0] m_addr;

  uart_pixel_loader #(
    .IMG_PIXELS     (IMG),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .wea         (wea),
    .addra       (addra),
    .dina        (dina),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Every write is matched against the oldest expected pixel.
  always @(negedge clk) begin
    if (wea === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addra=%0d dina=%h, no write expected", addra, dina);
      end else begin
        mon_e = sb.pop_front();
        if (addra !== mon_e.addr || dina !== mon_e.data || frame_done !== mon_e.fd) begin
          errors++;
          $display("FAIL pixel_write: got addra=%0d dina=%h frame_done=%b, expected addra=%0d dina=%h frame_done=%b",
                   addra, dina, frame_done, mon_e.addr, mon_e.data, mon_e.fd);
        end
      end
    end else if (frame_done === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL frame_done_without_wea: got frame_done=1 wea=%b, expected frame_done=0", wea);
    end
  end

  task automatic model_reset();
    m_idx  = 0;
    m_addr = '0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    exp_t e;
    if (m_idx == 0) begin
      m_r = b;
    end else if (m_idx == 1) begin
      m_g = b;
    end else begin
      e.addr = m_addr;
      e.data = {m_r, m_g, b};
      e.fd   = (m_addr == 18'(IMG - 1));
      sb.push_back(e);
      m_addr = (m_addr == 18'(IMG - 1)) ? 18'd0 : m_addr + 18'd1;
    end
    m_idx = (m_idx == 2) ? 0 : m_idx + 1;
  endtask

  // Caller is at a negedge; the strobe spans exactly the next posedge.
  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset for one cycle with a byte strobe that must be ignored.
  task automatic do_reset();
    reset    = 1'b1;
    rx_data  = 8'h77;
    rx_ready = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    rx_ready = 1'b0;
    sb.delete();
    model_reset();
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending writes, expected 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(3);
    do_reset();
    send_byte(8'h9A);
    send_byte(8'hBC);
    send_byte(8'hDE);
    drain("prereset");
    do_reset();
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++;
    if (wea !== 1'b0) begin errors++; $display("FAIL reset_wea: got %b expected 0", wea); end
    checks++;
    if (addra !== 18'd0) begin errors++; $display("FAIL reset_addra: got %0d expected 0", addra); end
    checks++;
    if (dina !== 24'd0) begin errors++; $display("FAIL reset_dina: got %h expected 000000", dina); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
  endtask

  task automatic test_single_pixel();
    send_byte(8'h12);
    idle(9);
    send_byte(8'h34);
    idle(9);
    send_byte(8'h56);
    checks++;
    if (wea !== 1'b1) begin errors++; $display("FAIL single_latency: got wea=%b expected 1", wea); end
    @(negedge clk);
    checks++;
    if (wea !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got wea=%b expected 0", wea); end
    drain("single");
  endtask

  task automatic test_frame_wrap();
    do_reset();
    for (int p = 0; p < IMG; p++) begin
      send_byte(8'(8'h10 * p + 1));
      idle(1);
      send_byte(8'(8'h10 * p + 2));
      send_byte(8'(8'h10 * p + 3));
      idle(2);
    end
    drain("frame");
    send_byte(8'hC1);
    send_byte(8'hC2);
    send_byte(8'hC3);
    drain("wrap");
  endtask

  task automatic test_back_to_back();
    send_byte(8'h21);
    send_byte(8'h22);
    send_byte(8'h23);
    send_byte(8'h31);
    send_byte(8'h32);
    send_byte(8'h33);
    drain("back_to_back");
  endtask

  task automatic test_reset_mid_pixel();
    send_byte(8'hAA);
    m_idx = 0;
    do_reset();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    drain("reset_mid");
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'h11);
    send_byte(8'h22);
    idle(40);
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL gap_40_state: got %0d expected 2", state); end
    idle(20);
`ifdef UART_LOADER_TIMEOUT_EN
    m_idx = 0;
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", timeout_err); end
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL timeout_state: got %0d expected 0", state); end
    send_byte(8'h0A);
    send_byte(8'h0B);
    send_byte(8'h0C);
    drain("after_timeout");
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", timeout_err); end
`else
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL no_timeout_err: got %b expected 0", timeout_err); end
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL no_timeout_state: got %0d expected 2", state); end
    send_byte(8'h33);
    drain("held_pixel");
`endif
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_pixel();
    test_frame_wrap();
    test_back_to_back();
    test_reset_mid_pixel();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
